// File: rtl/fifo_fill_ctrl.sv
// Frame fetch controller: issues memory bursts to keep a write-side FIFO above
// a low-water mark and streams the returned words into the FIFO.
module fifo_fill_ctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned LOW_WATER = 256
) (
  input  logic        aclr,
  input  logic        wrclk,
  input  logic        frame_start,
  input  logic [19:0] base_addr,
  input  logic [19:0] frame_words,
  input  logic [8:0]  fifo_wrusedw,
  output logic        fifo_wrreq,
  output logic [15:0] fifo_data,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  output logic [6:0]  mem_len,
  input  logic        mem_ack,
  input  logic        mem_dvalid,
  input  logic [15:0] mem_din,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned AW = 20;
  localparam int unsigned LW = 7;
  localparam int unsigned UW = 9;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rs_words;
  logic [LW-1:0] beats;
  logic [LW-1:0] burst_len_c;

  // Next burst is the smaller of the configured burst and what is left of the frame
  assign burst_len_c = (remaining < AW'(BURST_LEN)) ? LW'(remaining) : LW'(BURST_LEN);

  always_ff @(posedge wrclk or negedge aclr) begin
    if (!aclr) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      rs_addr    <= '0;
      rs_words   <= '0;
      beats      <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_len    <= '0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      fifo_wrreq <= 1'b0;

      // A write issued into a full FIFO is flagged until the next frame
      if (frame_start)
        ovf <= 1'b0;
      else if (fifo_wrreq && (fifo_wrusedw == '1))
        ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            addr      <= base_addr;
            remaining <= frame_words;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end

        CHECK: begin
          if (frame_start) begin
            addr      <= base_addr;
            remaining <= frame_words;
          end else if (remaining == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (fifo_wrusedw <= UW'(LOW_WATER)) begin
            mem_req  <= 1'b1;
            mem_addr <= addr;
            mem_len  <= burst_len_c;
            state    <= REQ;
          end
        end

        REQ: begin
          if (frame_start && mem_ack) begin
            mem_req  <= 1'b0;
            beats    <= mem_len;
            rs_addr  <= base_addr;
            rs_words <= frame_words;
            state    <= DRAIN;
          end else if (frame_start) begin
            mem_req   <= 1'b0;
            addr      <= base_addr;
            remaining <= frame_words;
            state     <= CHECK;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            beats   <= mem_len;
            state   <= DATA;
          end
        end

        DATA: begin
          if (frame_start) begin
            // Abandon delivery; a beat arriving with the restart is drained, not written
            rs_addr  <= base_addr;
            rs_words <= frame_words;
            if (mem_dvalid && (beats == LW'(1))) begin
              addr      <= base_addr;
              remaining <= frame_words;
              state     <= CHECK;
            end else begin
              if (mem_dvalid)
                beats <= beats - LW'(1);
              state <= DRAIN;
            end
          end else if (mem_dvalid) begin
            fifo_wrreq <= 1'b1;
            fifo_data  <= mem_din;
            beats      <= beats - LW'(1);
            if (beats == LW'(1)) begin
              addr      <= addr + AW'(mem_len);
              remaining <= remaining - AW'(mem_len);
              state     <= CHECK;
            end
          end
        end

        DRAIN: begin
          if (frame_start) begin
            rs_addr  <= base_addr;
            rs_words <= frame_words;
          end
          if (mem_dvalid) begin
            beats <= beats - LW'(1);
            if (beats == LW'(1)) begin
              addr      <= frame_start ? base_addr   : rs_addr;
              remaining <= frame_start ? frame_words : rs_words;
              state     <= CHECK;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl with a scoreboard of expected FIFO writes.
module tb_fifo_fill_ctrl;

  logic        aclr = 1'b0;
  logic        wrclk = 1'b0;
  logic        frame_start = 1'b0;
  logic [19:0] base_addr = '0;
  logic [19:0] frame_words = '0;
  logic [8:0]  fifo_wrusedw = '0;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [6:0]  mem_len;
  logic        mem_ack = 1'b0;
  logic        mem_dvalid = 1'b0;
  logic [15:0] mem_din = '0;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int wr_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  fifo_fill_ctrl #(.BURST_LEN(16), .LOW_WATER(256)) dut (
    .aclr(aclr), .wrclk(wrclk), .frame_start(frame_start), .base_addr(base_addr),
    .frame_words(frame_words), .fifo_wrusedw(fifo_wrusedw), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_dvalid(mem_dvalid), .mem_din(mem_din), .busy(busy), .ovf(ovf)
  );

  always #5 wrclk = ~wrclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every FIFO write must match the oldest expected word
  always @(negedge wrclk) begin
    if (fifo_wrreq === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(fifo_wrreq), 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("fifo_data", 32'(fifo_data), 32'(exp_w));
      end
    end
  end

  task automatic start_frame(input logic [19:0] a, input logic [19:0] w);
    frame_start = 1'b1;
    base_addr   = a;
    frame_words = w;
    @(negedge wrclk);
    frame_start = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60 && mem_req !== 1'b1; i++) @(negedge wrclk);
    chk("mem_req_seen", 32'(mem_req), 32'd1);
  endtask

  task automatic send_beats(input logic [19:0] a, input int n, input bit wr);
    for (int i = 0; i < n; i++) begin
      mem_dvalid = 1'b1;
      mem_din    = 16'(a) + 16'(i) ^ 16'h5A00;
      if (wr) begin
        exp_q.push_back(mem_din);
        pushes++;
      end
      @(negedge wrclk);
    end
    mem_dvalid = 1'b0;
  endtask

  task automatic serve(input logic [19:0] a, input logic [6:0] len, input int n);
    wait_req();
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("mem_len", 32'(mem_len), 32'(len));
    mem_ack = 1'b1;
    @(negedge wrclk);
    mem_ack = 1'b0;
    send_beats(a, n, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge wrclk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrreq"}, 32'(fifo_wrreq), 32'd0);
    chk({tag, "_data"}, 32'(fifo_data), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_len"}, 32'(mem_len), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    bit seen;
    @(negedge wrclk);
    chk_all_zero("reset");
    aclr = 1'b1;
    @(negedge wrclk);

    // Three bursts with a short tail
    start_frame(20'h00100, 20'd40);
    chk("t1_busy", 32'(busy), 32'd1);
    serve(20'h00100, 7'd16, 16);
    serve(20'h00110, 7'd16, 16);
    serve(20'h00120, 7'd8, 8);
    wait_idle();
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Fill above low water holds off the request
    fifo_wrusedw = 9'd300;
    start_frame(20'h00200, 20'd4);
    seen = 1'b0;
    repeat (20) begin
      seen |= mem_req;
      @(negedge wrclk);
    end
    chk("t2_no_req", 32'(seen), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    fifo_wrusedw = 9'd256;
    @(negedge wrclk);
    chk("t2_req_next", 32'(mem_req), 32'd1);
    serve(20'h00200, 7'd4, 4);
    fifo_wrusedw = 9'd0;
    wait_idle();

    // Address wraps past the top of the space
    start_frame(20'hFFFF8, 20'd32);
    serve(20'hFFFF8, 7'd16, 16);
    serve(20'h00008, 7'd16, 16);
    wait_idle();

    // Restart mid-burst drains the rest without writing
    start_frame(20'h00300, 20'd16);
    serve(20'h00300, 7'd16, 5);
    start_frame(20'h00400, 20'd16);
    chk("t4_busy_drain", 32'(busy), 32'd1);
    send_beats(20'h00DEA, 11, 1'b0);
    serve(20'h00400, 7'd16, 16);
    wait_idle();

    // Restart while requesting drops the request; stray beat ignored
    start_frame(20'h00700, 20'd20);
    wait_req();
    mem_dvalid = 1'b1;
    mem_din = 16'hBAD0;
    start_frame(20'h00800, 20'd8);
    mem_dvalid = 1'b0;
    chk("t5_req_drop", 32'(mem_req), 32'd0);
    serve(20'h00800, 7'd8, 8);
    wait_idle();

    // Restart coincident with acknowledge drains the whole burst
    start_frame(20'h00900, 20'd8);
    wait_req();
    chk("t6_addr", 32'(mem_addr), 32'h00900);
    mem_ack = 1'b1;
    start_frame(20'h00A00, 20'd4);
    mem_ack = 1'b0;
    send_beats(20'h00BAD, 8, 1'b0);
    serve(20'h00A00, 7'd4, 4);
    wait_idle();

    // Write into a full FIFO sets the sticky overflow
    start_frame(20'h00B00, 20'd4);
    wait_req();
    mem_ack = 1'b1;
    @(negedge wrclk);
    mem_ack = 1'b0;
    fifo_wrusedw = 9'd511;
    send_beats(20'h00B00, 1, 1'b1);
    chk("t7_ovf_pre", 32'(ovf), 32'd0);
    @(negedge wrclk);
    chk("t7_ovf_set", 32'(ovf), 32'd1);
    fifo_wrusedw = 9'd0;
    send_beats(20'h00B01, 3, 1'b1);
    wait_idle();
    chk("t7_ovf_sticky", 32'(ovf), 32'd1);
    start_frame(20'h00C00, 20'd0);
    chk("t7_ovf_clear", 32'(ovf), 32'd1 - 32'd1);
    chk("t8_zero_busy", 32'(busy), 32'd1);
    @(negedge wrclk);
    chk("t8_zero_idle", 32'(busy), 32'd0);
    chk("t8_zero_noreq", 32'(mem_req), 32'd0);

    // Reset in the middle of a burst
    start_frame(20'h00600, 20'd16);
    serve(20'h00600, 7'd16, 3);
    @(negedge wrclk);
    chk("t9_addr_pre", 32'(mem_addr), 32'h00600);
    aclr = 1'b0;
    mem_dvalid = 1'b1;
    mem_din = 16'hBEEF;
    #1;
    chk_all_zero("t9_reset");
    @(negedge wrclk);
    aclr = 1'b1;
    repeat (5) @(negedge wrclk);
    mem_dvalid = 1'b0;
    @(negedge wrclk);
    chk("t9_no_write", 32'(fifo_wrreq), 32'd0);
    chk("t9_idle", 32'(busy), 32'd0);

    repeat (3) @(negedge wrclk);
    chk("total_writes", 32'(wr_seen), 32'(pushes));
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_fill_ctrl.md
FIFO_FILL_CTRL -- requirements
Module: fifo_fill_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, maximum words per memory burst (1..64).
REQ-002 SHALL have parameter LOW_WATER, default 256, fill level at or below which a burst may start; LOW_WATER+BURST_LEN <= 511.
REQ-003 SHALL have port aclr  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wrclk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse, (re)start frame fetch.
REQ-006 SHALL have port base_addr  in  20  frame start word address, sampled on frame_start.
REQ-007 SHALL have port frame_words  in  20  words per frame, sampled on frame_start.
REQ-008 SHALL have port fifo_wrusedw  in  9  FIFO write-side fill level.
REQ-009 SHALL have port fifo_wrreq  out  1  FIFO write strobe.
REQ-010 SHALL have port fifo_data  out  16  FIFO write data.
REQ-011 SHALL have port mem_req  out  1  burst request, held until acknowledged.
REQ-012 SHALL have port mem_addr  out  20  burst start word address.
REQ-013 SHALL have port mem_len  out  7  burst length in words.
REQ-014 SHALL have port mem_ack  in  1  one-cycle request acknowledge.
REQ-015 SHALL have port mem_dvalid  in  1  read word valid.
REQ-016 SHALL have port mem_din  in  16  read word.
REQ-017 SHALL have port busy  out  1  high while frame incomplete or burst outstanding.
REQ-018 SHALL have port ovf  out  1  sticky overflow flag.

Function
REQ-019 SHALL implement states IDLE, CHECK, REQ, DATA, DRAIN.
REQ-020 IDLE: on frame_start latch addr=base_addr, remaining=frame_words, clear ovf, go CHECK.
REQ-021 CHECK: remaining=0 -> IDLE; else fifo_wrusedw <= LOW_WATER -> REQ with mem_len=min(BURST_LEN,remaining), mem_addr=addr; else stay CHECK.
REQ-022 REQ: mem_req=1, mem_addr/mem_len stable; on mem_ack go DATA with beat counter = mem_len.
REQ-023 DATA: each mem_dvalid decrements beat counter; last beat -> addr+=mem_len (mod 2^20), remaining-=mem_len, go CHECK.
REQ-024 Each accepted mem_dvalid in DATA SHALL produce fifo_wrreq=1 and fifo_data=mem_din exactly one cycle later (registered, latency 1).
REQ-025 mem_dvalid in IDLE, CHECK or REQ SHALL be ignored (no FIFO write).
REQ-026 frame_start in CHECK or REQ (before mem_ack) SHALL drop mem_req next cycle and restart as REQ-020 in the same edge.
REQ-027 frame_start in DATA SHALL go DRAIN: remaining beats consumed, FIFO writes suppressed, then restart with values latched at the frame_start.
REQ-028 frame_start in DRAIN SHALL replace latched restart values; drain continues.
REQ-029 frame_start coincident with mem_ack in REQ SHALL go DRAIN for mem_len beats.
REQ-030 frame_words=0 SHALL return to IDLE via CHECK with no request issued.
REQ-031 If a FIFO write is issued while fifo_wrusedw=511, ovf SHALL set and hold until next frame_start or reset; the write is still issued.
REQ-032 busy SHALL be low only in IDLE.

Reset
REQ-033 aclr low SHALL asynchronously force IDLE, fifo_wrreq=0, fifo_data=0, mem_req=0, mem_addr=0, mem_len=0, busy=0, ovf=0, internal counters 0.
REQ-034 Reset mid-burst SHALL abandon the burst; post-reset dvalids are ignored per REQ-025.

Verification
REQ-035 base_addr=0x00100, frame_words=40, wrusedw=0, ack/data immediate -> bursts (0x00100,16),(0x00110,16),(0x00120,8), 40 FIFO writes, busy low after.
REQ-036 wrusedw held 300 -> stays CHECK, mem_req never asserted; drop to 256 -> mem_req next cycle.
REQ-037 base_addr=0xFFFF8, frame_words=16 -> one burst at 0xFFFF8; final addr wraps to 0x00008.
REQ-038 frame_start after 5 of 16 beats -> 11 beats drained, zero fifo_wrreq, new burst at new base_addr.
REQ-039 write with wrusedw=511 -> ovf=1 next cycle, stays 1 until frame_start.
REQ-040 aclr low in DATA -> all outputs zero immediately; stray mem_dvalid afterwards produces no fifo_wrreq.
